shadow_inv_slws_seq: RTL and testbench

Sequential inverse of the Shadow-512 extended round A: undoes the per-bundle S-box / L-box / W32 / S-box step and its bundle rotation, one bundle per iteration. Four iterations restore the state that entered the forward round. Sits beside the forward round datapath in the Shadow-512 core. Used for inverse-permutation paths and as an on-chip self-check of the forward round.

---
 rtl/shadow_inv_slws_seq.sv | 156 +++++++++++++++
 tb/tb_shadow_inv_slws_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shadow_inv_slws_seq.sv
// Sequential inverse of the Shadow-512 extended round A: one bundle per iteration.
// Define SHADOW_INV_SLWS_PIPE_EN to register g after the inverse L-box (2 edges per iteration).
module shadow_inv_slws_seq #(
   parameter int Nbits   = 128,
   parameter int BAmount = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [BAmount*Nbits-1:0]   in_bundles_state,
   input  logic [32*BAmount-1:0]      in_W128,
   output logic [BAmount*Nbits-1:0]   out_bundles_state,
   output logic                       busy,
   output logic                       done
);

   localparam int SNbits = BAmount * Nbits;
   localparam int CW     = (BAmount > 1) ? $clog2(BAmount) : 1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] t;
      t = {x, x} >> n;
      return t[31:0];
   endfunction

   // Bitsliced: column i of the bundle is {row3[i],row2[i],row1[i],row0[i]}, so
   // bundle->cols->bundle collapses to operating on whole 32-bit rows.
   function automatic logic [127:0] sbox_inv_unit(input logic [127:0] b);
      logic [31:0] x0, x1, x2, x3, a0, a1, a2, a3;
      x0 = b[31:0];
      x1 = b[63:32];
      x2 = b[95:64];
      x3 = b[127:96];
      a3 = (x0 & x1) ^ x2;
      a0 = (x1 & a3) ^ x3;
      a1 = (a3 & a0) ^ x0;
      a2 = (a0 & a1) ^ x1;
      return {a3, a2, a1, a0};
   endfunction

   // Undoes the forward xor-rotate Feistel on a row pair, layers in reverse order.
   function automatic logic [63:0] lbox_inv_pair(input logic [31:0] x_in, input logic [31:0] y_in);
      logic [31:0] x, y;
      x = x_in;
      y = y_in;
      y = y ^ rotr(x, 15);
      x = x ^ rotr(y, 17) ^ rotr(y, 26);
      y = y ^ rotr(x, 12) ^ rotr(x, 3);
      return {y, x};
   endfunction

   function automatic logic [127:0] lbox_inv_unit(input logic [127:0] b);
      return {lbox_inv_pair(b[95:64], b[127:96]), lbox_inv_pair(b[31:0], b[63:32])};
   endfunction

   function automatic logic [127:0] add_w_row1(input logic [127:0] b, input logic [31:0] w);
      return b ^ {64'd0, w, 32'd0};
   endfunction

   logic [SNbits-1:0]    state_q, state_d;
   logic [32*BAmount-1:0] w_q, w_d;
   logic [CW-1:0]        j_q, j_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [Nbits-1:0]     y, stage1, g_out;
   logic [31:0]          w_cur;
   logic                 step;
   int                   w_idx;
`ifdef SHADOW_INV_SLWS_PIPE_EN
   logic [Nbits-1:0]     pipe_q, pipe_d;
   logic                 ph_q, ph_d;
`endif

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      j_d     = j_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      step    = 1'b0;
      y       = state_q[(BAmount-1)*Nbits +: Nbits];
      w_idx   = BAmount - 1 - int'(j_q);
      w_cur   = w_q[32*w_idx +: 32];
      stage1  = lbox_inv_unit(add_w_row1(sbox_inv_unit(y), w_cur));
`ifdef SHADOW_INV_SLWS_PIPE_EN
      pipe_d  = pipe_q;
      ph_d    = ph_q;
      g_out   = sbox_inv_unit(pipe_q);
`else
      g_out   = sbox_inv_unit(stage1);
`endif
      if (!busy_q) begin
         if (start) begin
            state_d = in_bundles_state;
            w_d     = in_W128;
            j_d     = '0;
            busy_d  = 1'b1;
`ifdef SHADOW_INV_SLWS_PIPE_EN
            ph_d    = 1'b0;
`endif
         end
      end else begin
`ifdef SHADOW_INV_SLWS_PIPE_EN
         if (!ph_q) begin
            pipe_d = stage1;
            ph_d   = 1'b1;
         end else begin
            ph_d = 1'b0;
            step = 1'b1;
         end
`else
         step = 1'b1;
`endif
         if (step) begin
            // Top bundle is consumed; its preimage re-enters at the bottom.
            state_d = {state_q[(BAmount-1)*Nbits-1:0], g_out};
            if (j_q == CW'(BAmount-1)) begin
               j_d    = '0;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         w_q     <= '0;
         j_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SHADOW_INV_SLWS_PIPE_EN
         pipe_q  <= '0;
         ph_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         j_q     <= j_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SHADOW_INV_SLWS_PIPE_EN
         pipe_q  <= pipe_d;
         ph_q    <= ph_d;
`endif
      end
   end

   assign out_bundles_state = state_q;
   assign busy              = busy_q;
   assign done              = done_q;

endmodule

// File: tb/tb_shadow_inv_slws_seq.sv
// Directed bench for shadow_inv_slws_seq: forward-model round trips, W sensitivity,
// held start, busy-time start rejection and mid-job reset.
module tb_shadow_inv_slws_seq;

`ifdef SHADOW_INV_SLWS_PIPE_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 4;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [511:0] in_bundles_state;
   logic [127:0] in_W128;
   logic [511:0] out_bundles_state;
   logic         busy;
   logic         done;

   int vectors = 0;
   int miscompares = 0;

   shadow_inv_slws_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .in_bundles_state(in_bundles_state), .in_W128(in_W128),
      .out_bundles_state(out_bundles_state), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Forward model: S-box, L-box, row-1 W add, S-box; then rotate bundles down.
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [127:0] sbox_fwd(input logic [127:0] b);
      logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3;
      x0 = b[31:0]; x1 = b[63:32]; x2 = b[95:64]; x3 = b[127:96];
      y1 = (x0 & x1) ^ x2;
      y0 = (x3 & x0) ^ x1;
      y3 = (y1 & x3) ^ x0;
      y2 = (y0 & y1) ^ x3;
      return {y3, y2, y1, y0};
   endfunction

   function automatic logic [63:0] lbox_pair(input logic [31:0] xi, input logic [31:0] yi);
      logic [31:0] x, y;
      x = xi; y = yi;
      y = y ^ rr(x, 12) ^ rr(x, 3);
      x = x ^ rr(y, 17) ^ rr(y, 26);
      y = y ^ rr(x, 15);
      return {y, x};
   endfunction

   function automatic logic [127:0] f_bundle(input logic [127:0] b, input logic [31:0] w);
      logic [127:0] t;
      t = sbox_fwd(b);
      t = {lbox_pair(t[95:64], t[127:96]), lbox_pair(t[31:0], t[63:32])};
      t[63:32] = t[63:32] ^ w;
      return sbox_fwd(t);
   endfunction

   function automatic logic [511:0] fwd_round(input logic [511:0] s, input logic [127:0] w);
      logic [511:0] t;
      t = s;
      for (int k = 0; k < 4; k++) t = {f_bundle(t[127:0], w[32*k +: 32]), t[511:128]};
      return t;
   endfunction

   // Entered and left at posedge+1. Optionally pokes start with junk while busy.
   task automatic run_job(input logic [511:0] s, input logic [127:0] w, input bit poke,
                          output logic [511:0] res, output int lat);
      start = 1'b1; in_bundles_state = s; in_W128 = w;
      @(posedge clk); #1;
      start = 1'b0; in_bundles_state = ~s; in_W128 = ~w;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (poke) start = (lat == 1 || lat == 2);
         if (done) break;
      end
      start = 1'b0;
      res = out_bundles_state;
   endtask

   logic [511:0] sa, sb, sp, sq, res, res2;
   logic [127:0] wa, wb, wc;
   int lat, n_done, d0, d1;

   initial begin
      sa = {128'h0123456789abcdef_fedcba9876543210, 128'hdeadbeef_cafef00d_13579bdf_2468ace0,
            128'h8badf00d_feedface_0badc0de_facefeed, 128'h00112233_44556677_8899aabb_ccddeeff};
      sb = {128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3, 128'h11111111_22222222_44444444_88888888,
            128'h00000001_80000000_7fffffff_fffffffe, 128'h9e3779b9_7f4a7c15_f39cc060_5cedc834};
      wa = 128'hb7e15162_8aed2a6a_bf715880_9cf4f3c7;
      wb = 128'h243f6a88_85a308d3_13198a2e_03707344;

      rst = 1'b1; start = 1'b0; in_bundles_state = '0; in_W128 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", out_bundles_state, '0);
      chk("rst_busy", {511'd0, busy}, '0);
      chk("rst_done", {511'd0, done}, '0);
      rst = 1'b0;

      // Round trip on a nontrivial state, then done must drop after one cycle
      sp = fwd_round(sa, wa);
      run_job(sp, wa, 1'b0, res, lat);
      chk("rt_a_lat", 512'(lat), 512'(LAT));
      chk("rt_a_res", res, sa);
      chk("rt_a_busy_at_done", {511'd0, busy}, '0);
      @(posedge clk); #1;
      chk("rt_a_done_pulse", {511'd0, done}, '0);
      chk("rt_a_hold", out_bundles_state, sa);

      // All-zero state, W = 0 and W = all ones
      sq = fwd_round('0, '0);
      run_job(sq, '0, 1'b0, res, lat);
      chk("rt_zero_w0", res, '0);
      sq = fwd_round('0, {128{1'b1}});
      run_job(sq, {128{1'b1}}, 1'b0, res, lat);
      chk("rt_zero_w1_lat", 512'(lat), 512'(LAT));
      chk("rt_zero_w1", res, '0);

      // W_3 bit 0 flipped on the same input: only bundle 3 moves
      wc = wa ^ (128'd1 << 96);
      run_job(sp, wc, 1'b0, res2, lat);
      chk("wsens_low3", {128'd0, res2[383:0]}, {128'd0, sa[383:0]});
      chk("wsens_b3_diff", {511'd0, (res2[511:384] != sa[511:384])}, 512'd1);
      chk("wsens_fwd", fwd_round(res2, wc), sp);

      // Start pulsed with junk inputs while busy: result unaffected
      sp = fwd_round(sb, wb);
      run_job(sp, wb, 1'b1, res, lat);
      chk("poke_lat", 512'(lat), 512'(LAT));
      chk("poke_res", res, sb);
      @(posedge clk); #1;

      // start held for 10 edges: accepts at edge 0 and on the first done cycle
      sp = fwd_round(sa, wa);
      start = 1'b1; in_bundles_state = sp; in_W128 = wa;
      n_done = 0; d0 = -1; d1 = -1;
      for (int e = 0; e < 2*LAT + 6; e++) begin
         @(posedge clk); #1;
         if (e == 9) start = 1'b0;
         if (done) begin
            if (n_done == 0) d0 = e; else d1 = e;
            n_done++;
            chk("hold_res", out_bundles_state, sa);
         end
      end
      start = 1'b0;
      chk("hold_ndone", 512'(n_done), 512'd2);
      chk("hold_d0", 512'(d0), 512'(LAT));
      chk("hold_d1", 512'(d1), 512'(2*LAT + 1));

      // Reset sampled at E2 of a job aborts it
      start = 1'b1; in_bundles_state = sp; in_W128 = wa;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out", out_bundles_state, '0);
      chk("midrst_busy", {511'd0, busy}, '0);
      chk("midrst_done", {511'd0, done}, '0);
      rst = 1'b0;
      sp = fwd_round(sb, wa);
      run_job(sp, wa, 1'b0, res, lat);
      chk("after_rst_lat", 512'(lat), 512'(LAT));
      chk("after_rst_res", res, sb);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
